// File: rtl/icu_pkg.sv
// Shared definitions for the 1-bit ICU program sequencer: opcode map,
// sequencer FSM state encoding and a small opcode classification helper.
package icu_pkg;

    // Datapath opcodes 0x0-0xB are issued to the control unit; 0xC-0xF are
    // flow-control opcodes executed inside the sequencer.
    typedef enum logic [3:0] {
        OP_NOOP = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_JSR  = 4'hD,
        OP_RTN  = 4'hE,
        OP_SKZ  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_e;

    // True for opcodes that go out to the datapath as an issue strobe.
    function automatic logic is_datapath_op(input opcode_e op);
        return (op <= OP_OEN);
    endfunction

endpackage : icu_pkg

// File: rtl/seq_ret_stack.sv
// Return-address LIFO for JSR/RTN. dout always shows the top entry; it is
// only meaningful while empty is low. Push when full and pop when empty are
// ignored (the sequencer flags those cases itself).
module seq_ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign top_idx = IDX_W'(cnt_q - CNT_W'(1));
    assign wr_idx  = IDX_W'(cnt_q);
    assign dout    = mem_q[top_idx];

    // Occupancy count next-state.
    always_comb begin
        cnt_d = cnt_q;
        if (do_push) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Occupancy register; reset empties the stack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry storage.
    // NOTE: storage has no reset; emptiness is tracked by cnt_q alone, so the
    // array can map onto plain flops or RAM without reset wiring.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule : seq_ret_stack

// File: rtl/program_sequencer.sv
// Fetch/sequence controller for the 1-bit ICU datapath. Fetches
// {opcode, operand} words over a req/ack handshake, issues datapath opcodes
// as one-cycle strobes and executes JMP/JSR/RTN/SKZ locally.
// Build option: define RET_STACK_EN to add the STACK_DEPTH-entry return
// stack; without it JSR and RTN act as NOOPs and err stays low.
module program_sequencer
    import icu_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [ADDR_W+3:0] mem_rdata,
    input  logic              rr,
    output logic              ins_valid,
    output logic [3:0]        ins_op,
    output logic [ADDR_W-1:0] ins_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              err
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    opcode_e           ir_op_q, ir_op_d;
    logic [ADDR_W-1:0] ir_operand_q, ir_operand_d;
    logic              skip_q, skip_d;
    logic              ins_valid_q, ins_valid_d;
    logic [3:0]        ins_op_q, ins_op_d;
    logic [ADDR_W-1:0] ins_addr_q, ins_addr_d;
    logic              err_q, err_d;
    logic              req_c;
    logic [ADDR_W-1:0] pc_inc;
    opcode_e           rd_op;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign rd_op  = opcode_e'(mem_rdata[ADDR_W+3:ADDR_W]);

`ifdef RET_STACK_EN
    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_dout;
    logic              stk_full;
    logic              stk_empty;

    seq_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );
`endif

    // Next-state, fetch request and issue decisions.
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_op_d      = ir_op_q;
        ir_operand_d = ir_operand_q;
        skip_d       = skip_q;
        ins_valid_d  = 1'b0;
        ins_op_d     = ins_op_q;
        ins_addr_d   = ins_addr_q;
        err_d        = err_q;
        req_c        = 1'b0;
`ifdef RET_STACK_EN
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    req_c   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    ir_op_d      = rd_op;
                    ir_operand_d = mem_rdata[ADDR_W-1:0];
                    state_d      = ST_EXEC;
                    // The strobe is registered here so it is high exactly
                    // for the EXEC cycle; skip cannot change before then.
                    if (!skip_q && is_datapath_op(rd_op)) begin
                        ins_valid_d = 1'b1;
                        ins_op_d    = rd_op;
                        ins_addr_d  = mem_rdata[ADDR_W-1:0];
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    case (ir_op_q)
                        OP_JMP: pc_d = ir_operand_q;
`ifdef RET_STACK_EN
                        OP_JSR: begin
                            if (stk_full) begin
                                err_d = 1'b1;
                            end else begin
                                stk_push = 1'b1;
                                pc_d     = ir_operand_q;
                            end
                        end
                        OP_RTN: begin
                            if (stk_empty) begin
                                err_d = 1'b1;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = stk_dout;
                            end
                        end
`endif
                        OP_SKZ: begin
                            if (!rr) begin
                                skip_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= '0;
            ir_op_q      <= OP_NOOP;
            ir_operand_q <= '0;
            skip_q       <= 1'b0;
            ins_valid_q  <= 1'b0;
            ins_op_q     <= '0;
            ins_addr_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_op_q      <= ir_op_d;
            ir_operand_q <= ir_operand_d;
            skip_q       <= skip_d;
            ins_valid_q  <= ins_valid_d;
            ins_op_q     <= ins_op_d;
            ins_addr_q   <= ins_addr_d;
            err_q        <= err_d;
        end
    end

    // Request is gated by rst so an in-flight fetch is dropped immediately.
    assign mem_req   = req_c && !rst;
    assign mem_addr  = pc_q;
    assign pc_out    = pc_q;
    assign ins_valid = ins_valid_q;
    assign ins_op    = ins_op_q;
    assign ins_addr  = ins_addr_q;
    assign err       = err_q;

endmodule : program_sequencer

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: directed programs push expected
// issues and fetch addresses; a memory model and an issue monitor compare.
module tb_program_sequencer;

    typedef struct {
        logic [3:0] op;
        logic [7:0] addr;
    } issue_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [11:0] mem_rdata = '0;
    logic        rr = 1'b0;
    logic        ins_valid;
    logic [3:0]  ins_op;
    logic [7:0]  ins_addr;
    logic [7:0]  pc_out;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [256];
    issue_t      exp_issue[$];
    logic [7:0]  exp_fetch[$];
    int          ack_dly = 0;
    int          ack_cnt = 0;
    int          req_cnt = 0;
    logic [7:0]  held_addr = '0;

    program_sequencer #(
        .ADDR_W      (8),
        .STACK_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rr        (rr),
        .ins_valid (ins_valid),
        .ins_op    (ins_op),
        .ins_addr  (ins_addr),
        .pc_out    (pc_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program memory: acks after ack_dly extra WAIT cycles, checks address stability and fetch order.
    always @(negedge clk) begin
        if (rst || !mem_req) begin
            req_cnt = 0;
            mem_ack = 1'b0;
        end else begin
            req_cnt++;
            if (req_cnt == 1) held_addr = mem_addr;
            else check("req_addr_stable", {24'd0, mem_addr}, {24'd0, held_addr});
            if (req_cnt == 2 + ack_dly) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                ack_cnt++;
                if (exp_fetch.size() == 0) begin
                    check("unexpected_fetch", {24'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    check("fetch_addr", {24'd0, mem_addr}, {24'd0, exp_fetch.pop_front()});
                end
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // Issue monitor: every strobe is matched against the scoreboard queue.
    always @(posedge clk) begin
        #1;
        if (ins_valid) begin
            if (exp_issue.size() == 0) begin
                check("unexpected_issue", {28'd0, ins_op}, 32'hFFFF_FFFF);
            end else begin
                issue_t e;
                e = exp_issue.pop_front();
                check("issue_op", {28'd0, ins_op}, {28'd0, e.op});
                check("issue_addr", {24'd0, ins_addr}, {24'd0, e.addr});
            end
        end
    end

    task automatic do_reset();
        rst     = 1'b1;
        run     = 1'b0;
        rr      = 1'b0;
        ack_dly = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        exp_issue.delete();
        exp_fetch.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_issue(input logic [3:0] op, input logic [7:0] addr);
        issue_t e;
        e.op   = op;
        e.addr = addr;
        exp_issue.push_back(e);
    endtask

    // Run exactly n instructions, halt, then verify scoreboard drained and final pc.
    task automatic run_prog(input int n, input logic [7:0] exp_pc, input string tag);
        int start;
        int c;
        start = ack_cnt;
        c     = 0;
        run   = 1'b1;
        while ((ack_cnt - start) < n && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        check({tag, "_timeout"}, (c < 400) ? 32'd1 : 32'd0, 32'd1);
        run = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_issues_left"}, exp_issue.size(), 0);
        check({tag, "_fetches_left"}, exp_fetch.size(), 0);
        check({tag, "_pc"}, {24'd0, pc_out}, {24'd0, exp_pc});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, and first-instruction timing.
        do_reset();
        mem[0] = {4'h1, 8'h05};
        exp_fetch.push_back(8'h00);
        expect_issue(4'h1, 8'h05);
        run = 1'b1;
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 0);
        check("rst_pc", {24'd0, pc_out}, 0);
        check("rst_ins_valid", {31'd0, ins_valid}, 0);
        check("rst_ins_op", {28'd0, ins_op}, 0);
        check("rst_ins_addr", {24'd0, ins_addr}, 0);
        check("rst_err", {31'd0, err}, 0);
        release_reset();
        #1;
        check("c1_mem_req", {31'd0, mem_req}, 1);
        check("c1_mem_addr", {24'd0, mem_addr}, 0);
        @(posedge clk);
        #1;
        check("c2_ins_valid", {31'd0, ins_valid}, 0);
        @(posedge clk);
        #1;
        check("c3_ins_valid", {31'd0, ins_valid}, 1);
        check("c3_ins_op", {28'd0, ins_op}, 1);
        check("c3_ins_addr", {24'd0, ins_addr}, 8'h05);
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t1_pc", {24'd0, pc_out}, 1);
        check("t1_halt_req", {31'd0, mem_req}, 0);
        check("t1_hold_op", {28'd0, ins_op}, 1);
        check("t1_hold_addr", {24'd0, ins_addr}, 8'h05);
        check("t1_queue", exp_issue.size(), 0);

        // Slow memory: address held, one strobe.
        do_reset();
        mem[0]  = {4'h3, 8'h11};
        ack_dly = 4;
        exp_fetch.push_back(8'h00);
        expect_issue(4'h3, 8'h11);
        release_reset();
        run_prog(1, 8'h01, "slow");

        // JMP then datapath op at the target.
        do_reset();
        mem[8'h00] = {4'hC, 8'h20};
        mem[8'h20] = {4'h3, 8'h09};
        exp_fetch.push_back(8'h00);
        exp_fetch.push_back(8'h20);
        expect_issue(4'h3, 8'h09);
        release_reset();
        run_prog(2, 8'h21, "jmp");

        // SKZ with rr=0 skips the next word; with rr=1 nothing is skipped.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            rr = (r == 1);
            mem[0] = {4'hF, 8'h00};
            mem[1] = {4'h5, 8'h01};
            mem[2] = {4'h6, 8'h02};
            exp_fetch.push_back(8'h00);
            exp_fetch.push_back(8'h01);
            exp_fetch.push_back(8'h02);
            if (r == 1) expect_issue(4'h5, 8'h01);
            expect_issue(4'h6, 8'h02);
            release_reset();
            run_prog(3, 8'h03, (r == 1) ? "skz_rr1" : "skz_rr0");
        end

        // pc wrap: NOOP at 0xFF falls through to 0x00.
        do_reset();
        mem[8'h00] = {4'hC, 8'hFF};
        mem[8'hFF] = {4'h0, 8'h33};
        exp_fetch.push_back(8'h00);
        exp_fetch.push_back(8'hFF);
        exp_fetch.push_back(8'h00);
        expect_issue(4'h0, 8'h33);
        release_reset();
        run_prog(3, 8'hFF, "wrap");

`ifdef RET_STACK_EN
        // Depth-2 stack: overflow, nested returns, underflow.
        do_reset();
        mem[8'h00] = {4'hD, 8'h10};
        mem[8'h10] = {4'hD, 8'h20};
        mem[8'h20] = {4'hD, 8'h30};
        mem[8'h21] = {4'hE, 8'h00};
        mem[8'h11] = {4'hE, 8'h00};
        mem[8'h01] = {4'hE, 8'h00};
        mem[8'h02] = {4'h7, 8'h0C};
        exp_fetch.push_back(8'h00);
        exp_fetch.push_back(8'h10);
        exp_fetch.push_back(8'h20);
        exp_fetch.push_back(8'h21);
        exp_fetch.push_back(8'h11);
        exp_fetch.push_back(8'h01);
        exp_fetch.push_back(8'h02);
        expect_issue(4'h7, 8'h0C);
        release_reset();
        run_prog(3, 8'h21, "jsr_full");
        check("jsr_full_err", {31'd0, err}, 1);
        run_prog(2, 8'h01, "rtn_nested");
        check("rtn_nested_err", {31'd0, err}, 1);
        run_prog(2, 8'h03, "rtn_empty");
        check("rtn_empty_err", {31'd0, err}, 1);
`else
        // Without the stack JSR/RTN are NOOPs and err stays low.
        do_reset();
        mem[0] = {4'hD, 8'h40};
        mem[1] = {4'hE, 8'h50};
        mem[2] = {4'h2, 8'h0A};
        exp_fetch.push_back(8'h00);
        exp_fetch.push_back(8'h01);
        exp_fetch.push_back(8'h02);
        expect_issue(4'h2, 8'h0A);
        release_reset();
        run_prog(3, 8'h03, "nostack");
        check("nostack_err", {31'd0, err}, 0);
`endif

        // Reset asserted mid-WAIT drops the request and clears pc.
        do_reset();
        mem[0] = {4'h1, 8'h01};
        mem[1] = {4'h2, 8'h02};
        exp_fetch.push_back(8'h00);
        expect_issue(4'h1, 8'h01);
        release_reset();
        run_prog(1, 8'h01, "pre_rst");
        ack_dly = 4;
        run = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("wait_req", {31'd0, mem_req}, 1);
        check("wait_addr", {24'd0, mem_addr}, 8'h01);
        #1;
        rst = 1'b1;
        #1;
        check("rst_wait_req", {31'd0, mem_req}, 0);
        check("rst_wait_pc", {24'd0, pc_out}, 0);
        check("rst_wait_valid", {31'd0, ins_valid}, 0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_program_sequencer

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetch/sequence controller for the 1-bit ICU datapath.
- Fetches {opcode, operand} words from program memory over a req/ack handshake and maintains the program counter.
- Issues datapath opcodes 0x0–0xB to the control unit as single-cycle pulses.
- Executes the flow-control opcodes 0xC–0xF locally: jump, call, return, skip-if-zero.

Parameters:
- ADDR_W, 8: program counter and operand width; program space is 2^ADDR_W words.
- STACK_DEPTH, 4: return-stack entries. Only meaningful with RET_STACK_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- run  in  1  enable; sampled only in FETCH.
- mem_req  out  1  fetch request.
- mem_addr  out  ADDR_W  fetch address, equals pc.
- mem_ack  in  1  fetch data valid this cycle.
- mem_rdata  in  4+ADDR_W  [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] operand.
- rr  in  1  result register from datapath; sampled by SKZ.
- ins_valid  out  1  one-cycle issue strobe to the control unit.
- ins_op  out  4  issued opcode.
- ins_addr  out  ADDR_W  operand, used as I/O select by the datapath.
- pc_out  out  ADDR_W  current pc.
- err  out  1  sticky stack error.

Behaviour:
- Reset (async, immediate):
  - pc=0, state=FETCH, mem_req=0, ins_valid=0, ins_op=0, ins_addr=0, skip=0, err=0, stack empty.
  - mem_req drops the instant rst asserts; any fetch in flight is abandoned.
- FSM states: FETCH, WAIT, EXEC.
- FETCH:
  - run=1: mem_req=1, mem_addr=pc; go to WAIT.
  - run=0: stay in FETCH, mem_req=0 (halted).
- WAIT:
  - mem_req held 1 and mem_addr held stable until mem_ack.
  - On the mem_ack cycle, capture mem_rdata into IR, drop mem_req the next cycle, go to EXEC.
- EXEC: exactly one cycle, then FETCH.
  - skip=1: clear skip, pc=pc+1, ins_valid stays 0, no opcode effect (including flow ops).
  - Opcode 0x0–0xB: ins_valid=1 for this cycle, ins_op=IR opcode, ins_addr=IR operand; pc=pc+1.
  - 0xC JMP: pc=operand; no issue.
  - 0xD JSR: push pc+1, then pc=operand.
  - 0xE RTN: pc=pop.
  - 0xF SKZ: if rr==0 set skip; pc=pc+1.
- Throughput: with zero-wait ack (ack arriving in the first WAIT cycle), 3 cycles per instruction (FETCH→WAIT→EXEC).
- Arithmetic: pc increment is modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- ins_op and ins_addr hold their last values between strobes; only ins_valid qualifies them.
- run deasserting during WAIT/EXEC does not abort; the current instruction completes and the block halts at the next FETCH.
- Simultaneous: rr is sampled only in the EXEC cycle of SKZ; mem_ack outside WAIT is ignored.

Optional Feature:
- Macro: RET_STACK_EN.
- Defined: STACK_DEPTH-entry LIFO for JSR/RTN.
  - JSR when the stack is full: no push, no jump, pc=pc+1, err=1.
  - RTN when the stack is empty: pc=pc+1, err=1.
  - err is sticky until rst.
- Undefined: 0xD and 0xE behave as NOOP (pc=pc+1, no issue, err never set); no stack storage is synthesized.

Decomposition:
- Shared package icu_pkg:
  - opcode constants OP_NOOP..OP_OEN (0x0–0xB), OP_JMP=0xC, OP_JSR=0xD, OP_RTN=0xE, OP_SKZ=0xF.
  - FSM state encoding.
- Sub-module seq_ret_stack:
  - ports: push, pop, din, dout, full, empty; same clk and async rst.
  - instantiated only under RET_STACK_EN.

Test Plan:
- Reset, run=1, memory with zero-wait ack; word@0={0x1,0x05} → mem_req in cycle 1, ins_valid=1 with ins_op=1, ins_addr=0x05 in cycle 3; pc_out=1 afterwards.
- mem_ack delayed 4 cycles → mem_addr constant and mem_req=1 throughout; exactly one ins_valid pulse.
- @0=JMP 0x20, @0x20=0x3 → next fetch address 0x20, ins_op=3 issued.
- @0=SKZ with rr=0, @1=0x5, @2=0x6 → 0x5 not issued, 0x6 issued. Repeat with rr=1 → both issued.
- RET_STACK_EN, STACK_DEPTH=2:
  - three nested JSRs → third is ignored (pc advances by 1) and err=1.
  - two RTNs → return to the pushed addresses in reverse order.
  - RTN on empty → err stays 1, pc+1.
- pc=0xFF (ADDR_W=8) executing 0x0 → next mem_addr=0x00. Assert rst during WAIT → mem_req=0 immediately, pc=0.
